// File: rtl/ntable_pkg.sv
// ntable_pkg: shared types and constants for the neighborTable read arbiter
package ntable_pkg;

   localparam int WORD_WIDTH = 16;
   localparam int IDX_WIDTH  = 6;
   localparam int NUM_REQ    = 4;

   localparam int REQ_REWARD = 0;
   localparam int REQ_KCH    = 1;
   localparam int REQ_QTUFMB = 2;
   localparam int REQ_FILTER = 3;

   typedef struct packed {
      logic [WORD_WIDTH-1:0] nodeID;
      logic [WORD_WIDTH-1:0] hops;
      logic [WORD_WIDTH-1:0] qValue;
      logic [WORD_WIDTH-1:0] energy;
      logic [WORD_WIDTH-1:0] chHops;
   } nt_entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot pick of the first asserted request at or after a pointer
module rr_pick #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic [N-1:0] gnt_o,
   output logic         valid_o
);

   logic [W-1:0] j;

   // scan farthest-to-nearest so the request closest to the pointer wins
   always_comb begin
      gnt_o = '0;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = W'((32'(ptr_i) + 32'(k)) % N);
         if (req_i[j]) gnt_o = {{(N-1){1'b0}}, 1'b1} << j;
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/ntable_read_arbiter.sv
// ntable_read_arbiter: round-robin sharing of the neighborTable read port with capped locked bursts
module ntable_read_arbiter #(
   parameter int NUM_REQ     = ntable_pkg::NUM_REQ,
   parameter int WORD_WIDTH  = ntable_pkg::WORD_WIDTH,
   parameter int IDX_WIDTH   = ntable_pkg::IDX_WIDTH,
   parameter int TABLE_DEPTH = 40,
   parameter int RD_LATENCY  = 1,
   parameter int MAX_BURST   = 8
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic                           en,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             lock,
   input  logic [NUM_REQ*IDX_WIDTH-1:0]   idx,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             rd_valid,
   output logic                           rd_err,
   output logic [5*WORD_WIDTH-1:0]        rdata,
   output logic                           tbl_rd_en,
   output logic [IDX_WIDTH-1:0]           tbl_rd_idx,
   input  logic [5*WORD_WIDTH-1:0]        tbl_rd_data,
   output logic                           busy
);

   import ntable_pkg::*;

   localparam int RW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST);

   arb_state_t                state_q, state_d;
   logic [NUM_REQ-1:0]        gnt_q, gnt_d, pick;
   logic                      pick_valid;
   logic [RW-1:0]             owner_q, owner_d, ptr_q, ptr_d, win;
   logic [IDX_WIDTH-1:0]      idx_q, idx_d;
   logic [2:0]                cnt_q, cnt_d;
   logic [BW-1:0]             burst_q, burst_d;
   logic [5*WORD_WIDTH-1:0]   rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      oor, cap, cont;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick),
      .valid_o (pick_valid)
   );

   // convert the one-hot winner into an index for idx selection and owner tracking
   always_comb begin
      win = '0;
      for (int k = 0; k < NUM_REQ; k++) if (pick[k]) win = RW'(k);
   end

   assign oor  = 32'(idx_q) >= TABLE_DEPTH;
   assign cap  = burst_q == BW'(MAX_BURST - 1);
   assign cont = en & lock[owner_q] & req[owner_q] & ~(cap & |(req & ~gnt_q));

   // next-state: grant, issue, wait out the table latency, return one entry
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      burst_d = burst_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE:
            if (en && pick_valid) begin
               state_d = ISSUE;
               gnt_d   = pick;
               owner_d = win;
               idx_d   = idx[IDX_WIDTH*win +: IDX_WIDTH];
            end
         ISSUE:
            if (oor) begin
               state_d = RETURN;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               state_d = WAIT;
               cnt_d   = 3'(RD_LATENCY);
            end
         WAIT:
            if (cnt_q == 3'd1) begin
               state_d = RETURN;
               rdata_d = tbl_rd_data;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         RETURN:
            if (cont) begin
               state_d = ISSUE;
               idx_d   = idx[IDX_WIDTH*owner_q +: IDX_WIDTH];
               burst_d = cap ? burst_q : burst_q + BW'(1);
            end else begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = (owner_q == RW'(NUM_REQ - 1)) ? '0 : owner_q + RW'(1);
               burst_d = '0;
            end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers; reset drops any in-flight table response
   always_ff @(posedge clk or posedge nrst) begin
      if (nrst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         burst_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         burst_q <= burst_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign gnt        = gnt_q;
   assign rd_valid   = (state_q == RETURN) ? gnt_q : '0;
   assign rd_err     = err_q;
   assign rdata      = rdata_q;
   assign tbl_rd_en  = (state_q == ISSUE) && !oor;
   assign tbl_rd_idx = tbl_rd_en ? idx_q : '0;
   assign busy       = state_q != IDLE;

endmodule

// File: tb/tb_ntable_read_arbiter.sv
// tb_ntable_read_arbiter: directed stimulus with a queue-based read-return scoreboard
module tb_ntable_read_arbiter;

   import ntable_pkg::*;

   logic        clk = 1'b0, nrst = 1'b1, en = 1'b0;
   logic [3:0]  req = '0, lock = '0;
   logic [23:0] idx = '0;
   logic [3:0]  gnt, rd_valid;
   logic        rd_err, tbl_rd_en, busy;
   logic [79:0] rdata, tbl_rd_data;
   logic [5:0]  tbl_rd_idx;

   int checks = 0, errors = 0, cyc = 0, c = 0;

   typedef struct {
      int          cyc;
      logic [3:0]  v;
      logic        e;
      logic [79:0] d;
   } exp_t;

   exp_t        sb[$];
   exp_t        got;
   logic [79:0] mem [0:63];
   int          cidx [4] = '{3, 7, 11, 39};

   ntable_read_arbiter dut (
      .clk         (clk),
      .nrst        (nrst),
      .en          (en),
      .req         (req),
      .lock        (lock),
      .idx         (idx),
      .gnt         (gnt),
      .rd_valid    (rd_valid),
      .rd_err      (rd_err),
      .rdata       (rdata),
      .tbl_rd_en   (tbl_rd_en),
      .tbl_rd_idx  (tbl_rd_idx),
      .tbl_rd_data (tbl_rd_data),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // table model: data valid one cycle after the strobe, all-ones otherwise
   always @(posedge clk) tbl_rd_data <= tbl_rd_en ? mem[tbl_rd_idx] : '1;

   function automatic logic [79:0] ent(input int i);
      nt_entry_t t;
      t.nodeID = 16'h0100 + 16'(i);
      t.hops   = 16'(i % 7);
      t.qValue = 16'h1000 + 16'(i * 3);
      t.energy = 16'hA000 + 16'(i);
      t.chHops = 16'(i % 3);
      if (i == 5) t = 80'h0007_0002_1234_8000_0001;
      return t;
   endfunction

   initial for (int i = 0; i < 64; i++) mem[i] = ent(i);

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int at, input logic [3:0] v, input logic e, input logic [79:0] d);
      exp_t x;
      x.cyc = at;
      x.v = v;
      x.e = e;
      x.d = d;
      sb.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor: every rd_valid pulse must match the oldest expected return
   always @(negedge clk) begin
      if (rd_valid !== 4'b0000) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rd_valid: got %b expected none (cycle %0d)", rd_valid, cyc);
         end else begin
            got = sb.pop_front();
            chk("rd_cycle", 80'(cyc), 80'(got.cyc));
            chk("rd_valid", 80'(rd_valid), 80'(got.v));
            chk("rd_err", 80'(rd_err), 80'(got.e));
            chk("rdata", rdata, got.d);
         end
      end
   end

   initial begin
      step(1);
      chk("reset_gnt", 80'(gnt), 0);
      chk("reset_rd_valid", 80'(rd_valid), 0);
      chk("reset_rd_err", 80'(rd_err), 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_tbl_rd_en", 80'(tbl_rd_en), 0);
      chk("reset_tbl_rd_idx", 80'(tbl_rd_idx), 0);
      chk("reset_busy", 80'(busy), 0);
      nrst = 1'b0;
      step(1);

      // contention: all four requesting, grants 0,1,2,3,0 every 4 cycles
      en = 1'b1;
      idx = {6'd39, 6'd11, 6'd7, 6'd3};
      req = 4'b1111;
      c = cyc;
      for (int k = 0; k < 5; k++) push(c + 3 + 4 * k, 4'(1 << (k % 4)), 1'b0, ent(cidx[k % 4]));
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("rr_gnt", 80'(gnt), 80'(1 << (k % 4)));
         chk("rr_strobe", 80'(tbl_rd_en), 1);
         chk("rr_tbl_idx", 80'(tbl_rd_idx), 80'(cidx[k % 4]));
         if (k < 4) step(3);
         else begin
            step(2);
            req = 4'b0000;
            step(1);
         end
      end

      // single read of the reference entry 5
      idx = {6'd63, 6'd63, 6'd63, 6'd5};
      req = 4'b0001;
      c = cyc;
      push(c + 3, 4'b0001, 1'b0, 80'h0007_0002_1234_8000_0001);
      step(1);
      chk("single_gnt", 80'(gnt), 80'(1 << REQ_REWARD));
      chk("single_strobe", 80'(tbl_rd_en), 1);
      chk("single_tbl_idx", 80'(tbl_rd_idx), 5);
      chk("single_busy", 80'(busy), 1);
      step(1);
      chk("wait_no_strobe", 80'(tbl_rd_en), 0);
      step(1);
      req = 4'b0000;
      step(1);
      chk("single_release", 80'(gnt), 0);
      chk("single_idle", 80'(busy), 0);

      // out-of-range index: no strobe, error return two cycles after the decision
      idx = {6'd0, 6'd0, 6'd40, 6'd0};
      req = 4'b0010;
      c = cyc;
      push(c + 2, 4'b0010, 1'b1, 80'h0);
      step(1);
      chk("oor_gnt", 80'(gnt), 80'(1 << REQ_KCH));
      chk("oor_no_strobe", 80'(tbl_rd_en), 0);
      step(1);
      req = 4'b0000;
      step(1);
      chk("oor_idle", 80'(busy), 0);

      // locked burst with a competitor: capped at 8 reads, then QTUFMB gets the port
      idx = {6'd0, 6'd20, 6'd0, 6'd0};
      lock = 4'b0001;
      req = 4'b0001;
      c = cyc;
      for (int k = 0; k < 8; k++) push(c + 3 + 3 * k, 4'b0001, 1'b0, ent(k));
      push(c + 28, 4'b0100, 1'b0, ent(20));
      step(1);
      chk("burst_gnt", 80'(gnt), 1);
      req[2] = 1'b1;
      step(2);
      for (int k = 0; k < 8; k++) begin
         idx[5:0] = 6'(k + 1);
         if (k < 7) step(3);
      end
      step(1);
      req[0] = 1'b0;
      lock = 4'b0000;
      chk("cap_release", 80'(gnt), 0);
      step(1);
      chk("cap_next_owner", 80'(gnt), 80'(1 << REQ_QTUFMB));
      step(2);
      req = 4'b0000;
      step(1);

      // locked burst without competition: all 10 reads stay with requester 0
      idx = '0;
      lock = 4'b0001;
      req = 4'b0001;
      c = cyc;
      for (int k = 0; k < 10; k++) push(c + 3 + 3 * k, 4'b0001, 1'b0, ent(k));
      step(3);
      for (int k = 0; k < 10; k++) begin
         if (k < 9) begin
            idx[5:0] = 6'(k + 1);
            step(3);
         end else begin
            req = 4'b0000;
            lock = 4'b0000;
         end
      end
      step(1);
      chk("burst10_idle", 80'(busy), 0);

      // en drops mid-read: read completes, lock ignored, owner released
      idx = {6'd0, 6'd0, 6'd0, 6'd9};
      lock = 4'b0001;
      req = 4'b0001;
      c = cyc;
      push(c + 3, 4'b0001, 1'b0, ent(9));
      step(1);
      en = 1'b0;
      step(3);
      chk("en_drop_busy", 80'(busy), 0);
      chk("en_drop_gnt", 80'(gnt), 0);
      req = 4'b0000;
      lock = 4'b0000;

      // enable gating: no grant while en=0, grant one cycle after it rises
      idx = {6'd0, 6'd0, 6'd12, 6'd0};
      req = 4'b0010;
      step(3);
      chk("en_low_gnt", 80'(gnt), 0);
      chk("en_low_busy", 80'(busy), 0);
      en = 1'b1;
      c = cyc;
      push(c + 3, 4'b0010, 1'b0, ent(12));
      step(1);
      chk("en_rise_gnt", 80'(gnt), 80'(1 << REQ_KCH));
      step(2);
      req = 4'b0000;
      step(1);

      // asynchronous reset during WAIT clears everything and discards the response
      idx = {6'd0, 6'd15, 6'd0, 6'd0};
      req = 4'b0100;
      step(2);
      chk("pre_reset_busy", 80'(busy), 1);
      nrst = 1'b1;
      #1;
      chk("rst_gnt", 80'(gnt), 0);
      chk("rst_busy", 80'(busy), 0);
      chk("rst_strobe", 80'(tbl_rd_en), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rd_err", 80'(rd_err), 0);
      step(1);
      chk("rst_rd_valid", 80'(rd_valid), 0);
      req = 4'b0000;
      nrst = 1'b0;
      step(4);

      for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
      chk("sb_drain", 80'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
